// File: rtl/ice40_gpio_sequencer.sv
// rtl/ice40_gpio_sequencer.sv - pattern sequencer driving an ice40_gpiobank OV register
// Slave register window holds pattern table and timing; master port replays patterns at DIV+2 cadence.
module ice40_gpio_sequencer #(
  parameter logic [31:0] ADDR      = 32'ha100,
  parameter logic [31:0] GPIO_ADDR = 32'ha000,
  parameter int          N_IO      = 4,
  parameter int          DEPTH     = 8,
  parameter int          DIV_W     = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [3:0]  wmask,
  input  logic        wen,
  input  logic        ren,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        active,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  output logic [3:0]  m_wmask,
  output logic        m_wen,
  output logic        m_ren,
  input  logic        m_ready
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_WAIT} state_t;

  state_t          state, state_d;
  logic            run, loop;
  logic [DIV_W-1:0] div_q, cnt, cnt_d;
  logic [4:0]      len_q;
  logic [N_IO-1:0] pat [DEPTH];
  logic [IW-1:0]   idx, idx_d;
  logic [N_IO-1:0] wdata_q;
  logic            run_hw_clr;

  logic [29:0]     word_off;
  logic [IW-1:0]   pat_sel;
  logic [31:0]     bmask;
  logic            bus_we, we_ctrl, we_div, we_len, we_pat;
  logic [4:0]      eff_len;
  logic            last_step;
  logic            sig_unused;

  // Word offset wraps huge for addresses below ADDR, so one compare covers both bounds.
  assign word_off = addr[31:2] - ADDR[31:2];
  assign active   = word_off < 30'(DEPTH + 4);
  assign pat_sel  = IW'(word_off - 30'd4);
  assign bmask    = {{8{wmask[3]}}, {8{wmask[2]}}, {8{wmask[1]}}, {8{wmask[0]}}};

  assign bus_we  = wen && active;
  assign we_ctrl = bus_we && (word_off == 30'd0);
  assign we_div  = bus_we && (word_off == 30'd1);
  assign we_len  = bus_we && (word_off == 30'd2);
  assign we_pat  = bus_we && (word_off >= 30'd4);

  assign ready      = 1'b1;
  assign m_ren      = 1'b0;
  assign m_addr     = GPIO_ADDR + 32'd4;
  assign m_wen      = (state == S_WRITE);
  assign m_wmask    = {4{m_wen}};
  assign m_wdata    = 32'(wdata_q);
  assign sig_unused = &{1'b0, ren, addr[1:0], wdata, bmask};

  always_comb begin
    rdata = '0;
    if (active) begin
      case (word_off)
        30'd0:   rdata = {30'd0, loop, run};
        30'd1:   rdata = 32'(div_q);
        30'd2:   rdata = {27'd0, len_q};
        30'd3:   rdata = {20'd0, 4'(idx), 7'd0, (state != S_IDLE)};
        default: rdata = 32'(pat[pat_sel]);
      endcase
    end
  end

  always_comb begin
    eff_len = len_q;
    if (len_q == 5'd0)
      eff_len = 5'd1;
    else if (len_q > 5'(DEPTH))
      eff_len = 5'(DEPTH);
  end

  assign last_step = (5'(idx) == eff_len - 5'd1);

  always_comb begin
    state_d    = state;
    idx_d      = idx;
    cnt_d      = cnt;
    run_hw_clr = 1'b0;
    case (state)
      S_IDLE: begin
        if (run) begin
          idx_d   = '0;
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        // A transfer in flight always completes; RUN is only consulted once it is accepted.
        if (m_ready) begin
          if (!run) begin
            state_d = S_IDLE;
          end else begin
            cnt_d   = div_q;
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (!run) begin
          state_d = S_IDLE;
        end else if (cnt != '0) begin
          cnt_d = cnt - 1'b1;
        end else if (last_step) begin
          if (loop) begin
            idx_d   = '0;
            state_d = S_WRITE;
          end else begin
            run_hw_clr = 1'b1;
            state_d    = S_IDLE;
          end
        end else begin
          idx_d   = idx + 1'b1;
          state_d = S_WRITE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      idx     <= '0;
      cnt     <= '0;
      wdata_q <= '0;
    end else begin
      state <= state_d;
      idx   <= idx_d;
      cnt   <= cnt_d;
      // Pattern is captured on entry to WRITE so later PAT writes cannot disturb a held transfer.
      if (state_d == S_WRITE && state != S_WRITE)
        wdata_q <= pat[idx_d];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run   <= 1'b0;
      loop  <= 1'b0;
      div_q <= '0;
      len_q <= 5'd1;
      for (int k = 0; k < DEPTH; k++)
        pat[k] <= '0;
    end else begin
      if (we_ctrl && wmask[0]) begin
        run  <= wdata[0];
        loop <= wdata[1];
      end else if (run_hw_clr) begin
        run <= 1'b0;
      end
      if (we_div)
        div_q <= (div_q & ~bmask[DIV_W-1:0]) | (wdata[DIV_W-1:0] & bmask[DIV_W-1:0]);
      if (we_len && wmask[0])
        len_q <= wdata[4:0];
      if (we_pat)
        pat[pat_sel] <= (pat[pat_sel] & ~bmask[N_IO-1:0]) | (wdata[N_IO-1:0] & bmask[N_IO-1:0]);
    end
  end

endmodule

// File: tb/tb_ice40_gpio_sequencer.sv
// tb/tb_ice40_gpio_sequencer.sv - self-checking bench for ice40_gpio_sequencer
module tb_ice40_gpio_sequencer;

  localparam logic [31:0] ADDR      = 32'ha100;
  localparam logic [31:0] GPIO_ADDR = 32'ha000;
  localparam int          N_IO      = 4;
  localparam int          DEPTH     = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] addr = '0, wdata = '0;
  logic [3:0]  wmask = '0;
  logic        wen = 1'b0, ren = 1'b0;
  logic [31:0] rdata, m_addr, m_wdata;
  logic        ready, active, m_wen, m_ren;
  logic [3:0]  m_wmask;
  logic        m_ready = 1'b1;

  ice40_gpio_sequencer #(.ADDR(ADDR), .GPIO_ADDR(GPIO_ADDR), .N_IO(N_IO), .DEPTH(DEPTH), .DIV_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .addr(addr), .wdata(wdata), .wmask(wmask), .wen(wen), .ren(ren),
    .rdata(rdata), .ready(ready), .active(active), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_wmask(m_wmask), .m_wen(m_wen), .m_ren(m_ren), .m_ready(m_ready)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", name, got, exp);
    end
  endtask

  // Transfer log gathered from the master port; the model judges it afterwards.
  typedef struct {
    int          start;
    int          done;
    logic [31:0] data;
    logic [31:0] a;
  } xfer_t;

  xfer_t       xq[$];
  bit          in_xfer = 1'b0;
  int          xs = 0;
  logic [31:0] held = '0;
  int          proto_err = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      in_xfer = 1'b0;
    end else if (m_wen) begin
      if (m_wmask !== 4'hf || m_ren !== 1'b0 || ready !== 1'b1) proto_err++;
      if (!in_xfer) begin
        in_xfer = 1'b1;
        xs      = cyc;
        held    = m_wdata;
      end else if (m_wdata !== held) begin
        proto_err++;
      end
      if (m_ready) begin
        xq.push_back('{xs, cyc, m_wdata, m_addr});
        in_xfer = 1'b0;
      end
    end else if (m_wmask !== 4'h0) begin
      proto_err++;
    end
  end

  bit rnd_ready = 1'b0;
  initial forever begin
    @(posedge clk);
    #1;
    if (rnd_ready) m_ready = ($urandom_range(0, 3) != 0);
  end

  logic [N_IO-1:0] mp[DEPTH];
  int              wr_cyc = 0;

  task automatic wr(input int off, input logic [31:0] d, input logic [3:0] m = 4'hf);
    addr  = ADDR + 32'(off);
    wdata = d;
    wmask = m;
    wen   = 1'b1;
    @(posedge clk);
    #1;
    wen    = 1'b0;
    wr_cyc = cyc;
  endtask

  task automatic rd(input int off, output logic [31:0] d);
    addr = ADDR + 32'(off);
    ren  = 1'b1;
    #1;
    d   = rdata;
    ren = 1'b0;
  endtask

  task automatic set_pat(input int k, input logic [31:0] v);
    wr(16 + 4 * k, v);
    mp[k] = v[N_IO-1:0];
  endtask

  task automatic wait_idle(input int budget, input string name);
    logic [31:0] s;
    int n = 0;
    @(posedge clk);
    #1;
    rd(12, s);
    while (s[0] && n < budget) begin
      @(posedge clk);
      #1;
      rd(12, s);
      n++;
    end
    check({name, "_idle_timeout"}, {31'd0, s[0]}, 32'd0);
  endtask

  // Transfer k carries PAT[k mod L]; each starts DIV+2 cycles after the previous one was accepted.
  task automatic check_seq(input int L, input int div, input int first, input string tag);
    for (int k = 0; k < xq.size(); k++) begin
      check($sformatf("%s_data%0d", tag, k), xq[k].data, 32'(mp[k % L]));
      check($sformatf("%s_maddr%0d", tag, k), xq[k].a, GPIO_ADDR + 32'd4);
      if (k == 0)
        check($sformatf("%s_start", tag), 32'(xq[0].start), 32'(first));
      else
        check($sformatf("%s_gap%0d", tag, k), 32'(xq[k].start - xq[k-1].done), 32'(div + 2));
    end
  endtask

  task automatic check_reset_vals(input string tag);
    logic [31:0] r;
    rd(0, r);  check({tag, "_ctrl"}, r, 32'd0);
    rd(4, r);  check({tag, "_div"}, r, 32'd0);
    rd(8, r);  check({tag, "_len"}, r, 32'd1);
    rd(12, r); check({tag, "_status"}, r, 32'd0);
    rd(16, r); check({tag, "_pat0"}, r, 32'd0);
    rd(44, r); check({tag, "_pat7"}, r, 32'd0);
  endtask

  typedef struct {
    int          off;
    logic [31:0] d;
    logic [3:0]  m;
    logic [31:0] exp;
    bit          act;
  } reg_vec_t;

  reg_vec_t vec[$];

  initial begin
    logic [31:0] r;
    int          n;
    int          len, div, L;

    vec = '{
      '{4,  32'h0000_1234, 4'hf, 32'h0000_1234, 1'b1},
      '{4,  32'h0000_beef, 4'h1, 32'h0000_12ef, 1'b1},
      '{4,  32'habcd_0000, 4'hf, 32'h0000_0000, 1'b1},
      '{8,  32'h0000_00ff, 4'hf, 32'h0000_001f, 1'b1},
      '{8,  32'h0000_0014, 4'h2, 32'h0000_001f, 1'b1},
      '{12, 32'hffff_ffff, 4'hf, 32'h0000_0000, 1'b1},
      '{28, 32'hffff_ffff, 4'hf, 32'h0000_000f, 1'b1},
      '{28, 32'h0000_0000, 4'h0, 32'h0000_000f, 1'b1},
      '{44, 32'h0000_000a, 4'hf, 32'h0000_000a, 1'b1},
      '{48, 32'h0000_0055, 4'hf, 32'h0000_0000, 1'b0},
      '{-4, 32'h0000_0055, 4'hf, 32'h0000_0000, 1'b0},
      '{0,  32'h0000_0002, 4'hf, 32'h0000_0002, 1'b1},
      '{0,  32'h0000_0000, 4'hf, 32'h0000_0000, 1'b1}
    };
    for (int k = 0; k < DEPTH; k++) mp[k] = '0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_mwen", {31'd0, m_wen}, 32'd0);
    check("rst_mwdata", m_wdata, 32'd0);
    check_reset_vals("rst");
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Register file vectors.
    for (int i = 0; i < vec.size(); i++) begin
      wr(vec[i].off, vec[i].d, vec[i].m);
      rd(vec[i].off, r);
      check($sformatf("reg%0d_rdata", i), r, vec[i].exp);
      check($sformatf("reg%0d_active", i), {31'd0, active}, {31'd0, vec[i].act});
    end
    mp[3] = 4'hf;
    mp[7] = 4'ha;

    // One-shot 1,2,4 with DIV=3.
    set_pat(0, 1); set_pat(1, 2); set_pat(2, 4);
    wr(8, 3); wr(4, 3);
    xq.delete();
    wr(0, 1);
    n = wr_cyc;
    wait_idle(500, "oneshot");
    check("oneshot_count", 32'(xq.size()), 32'd3);
    check_seq(3, 3, n + 1, "oneshot");
    rd(0, r); check("oneshot_ctrl", r, 32'd0);

    // Loop LEN=2 DIV=0, then stop.
    set_pat(0, 1); set_pat(1, 2);
    wr(8, 2); wr(4, 0);
    xq.delete();
    wr(0, 3);
    n = wr_cyc;
    len = 0;
    while (xq.size() < 4 && len < 200) begin
      @(negedge clk);
      #1;
      len++;
    end
    check("loop_reach4", {31'd0, xq.size() >= 4}, 32'd1);
    wr(0, 0);
    rd(12, r); check("loop_stop_wait_busy", {31'd0, r[0]}, 32'd1);
    @(posedge clk);
    #1;
    rd(12, r); check("loop_stop_idle", {31'd0, r[0]}, 32'd0);
    repeat (10) @(posedge clk);
    #1;
    check("loop_count", 32'(xq.size()), 32'd4);
    check_seq(2, 0, n + 1, "loop");

    // Stall with RUN cleared during the held transfer.
    m_ready = 1'b0;
    set_pat(0, 5); set_pat(1, 6);
    xq.delete();
    wr(0, 3);
    for (int i = 0; i < 4; i++) begin
      if (i == 1) wr(0, 0);
      else begin
        @(posedge clk);
        #1;
      end
      check($sformatf("stall_mwen%0d", i), {31'd0, m_wen}, 32'd1);
      check($sformatf("stall_mwdata%0d", i), m_wdata, 32'd5);
    end
    m_ready = 1'b1;
    @(posedge clk);
    #1;
    check("stall_done_mwen", {31'd0, m_wen}, 32'd0);
    repeat (5) @(posedge clk);
    #1;
    check("stall_count", 32'(xq.size()), 32'd1);
    if (xq.size() > 0) check("stall_data", xq[0].data, 32'd5);
    rd(12, r); check("stall_status", r, 32'd0);

    // LEN=0 behaves as a single step.
    wr(8, 0); wr(4, 1);
    xq.delete();
    wr(0, 1);
    n = wr_cyc;
    wait_idle(200, "len0");
    check("len0_count", 32'(xq.size()), 32'd1);
    check_seq(1, 1, n + 1, "len0");

    // LEN=20 clamps to DEPTH; loop wraps the index.
    for (int k = 0; k < DEPTH; k++) set_pat(k, $urandom);
    wr(8, 20); wr(4, 0);
    xq.delete();
    wr(0, 3);
    n = wr_cyc;
    len = 0;
    while (xq.size() < 12 && len < 500) begin
      @(negedge clk);
      #1;
      len++;
    end
    wr(0, 0);
    wait_idle(200, "len20");
    check("len20_reach12", {31'd0, xq.size() >= 12}, 32'd1);
    check_seq(DEPTH, 0, n + 1, "len20");

    // Randomised one-shots, some with random m_ready stalls.
    for (int it = 0; it < 12; it++) begin
      for (int k = 0; k < DEPTH; k++) set_pat(k, $urandom);
      len = $urandom_range(0, 20);
      div = $urandom_range(0, 4);
      L   = (len == 0) ? 1 : (len > DEPTH) ? DEPTH : len;
      wr(8, 32'(len)); wr(4, 32'(div));
      rnd_ready = it[0];
      xq.delete();
      wr(0, 1);
      n = wr_cyc;
      wait_idle(3000, $sformatf("rnd%0d", it));
      rnd_ready = 1'b0;
      m_ready   = 1'b1;
      check($sformatf("rnd%0d_count", it), 32'(xq.size()), 32'(L));
      check_seq(L, div, n + 1, $sformatf("rnd%0d", it));
      rd(0, r); check($sformatf("rnd%0d_ctrl", it), r, 32'd0);
    end
    check("protocol_errors", 32'(proto_err), 32'd0);

    // Reset asserted mid-transfer drops m_wen without a clock edge.
    m_ready = 1'b0;
    wr(0, 1);
    @(posedge clk);
    #1;
    check("midrst_pre_mwen", {31'd0, m_wen}, 32'd1);
    #3;
    rst_n = 1'b0;
    #1;
    check("midrst_mwen", {31'd0, m_wen}, 32'd0);
    check("midrst_mwmask", {28'd0, m_wmask}, 32'd0);
    check("midrst_mwdata", m_wdata, 32'd0);
    check_reset_vals("midrst");
    @(posedge clk);
    #1;
    rst_n   = 1'b1;
    m_ready = 1'b1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
